// File: rtl/gate_bist_pkg.sv
// Shared types, constants and the gate truth-table function for gate_bist.
package gate_bist_pkg;

  localparam int unsigned Y_W   = 8;
  localparam int unsigned VEC_W = 2;
  localparam int unsigned CNT_W = 8;

  // Bit positions of each gate output within y
  localparam int unsigned Y_BUF  = 0;
  localparam int unsigned Y_AND  = 1;
  localparam int unsigned Y_OR   = 2;
  localparam int unsigned Y_XOR  = 3;
  localparam int unsigned Y_NOT  = 4;
  localparam int unsigned Y_NAND = 5;
  localparam int unsigned Y_NOR  = 6;
  localparam int unsigned Y_XNOR = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Expected gate-block response for one input vector
  function automatic logic [Y_W-1:0] gate_expect(input logic a, input logic b);
    logic [Y_W-1:0] e;
    e         = '0;
    e[Y_BUF]  = a;
    e[Y_AND]  = a & b;
    e[Y_OR]   = a | b;
    e[Y_XOR]  = a ^ b;
    e[Y_NOT]  = ~b;
    e[Y_NAND] = ~(a & b);
    e[Y_NOR]  = ~(a | b);
    e[Y_XNOR] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_bist_ref_model.sv
// Combinational expected-output generator for the gate block.
module gate_ref_model
  import gate_bist_pkg::*;
(
  input  logic           a,
  input  logic           b,
  output logic [Y_W-1:0] expected_c
);

  // Truth-table lookup for the currently driven vector
  always_comb begin
    expected_c = gate_expect(a, b);
  end

endmodule

// File: rtl/gate_bist.sv
// Self-test sequencer for the two-input gate block: drives all four {a,b}
// vectors, checks y after a settle time, reports pass / fail mask.
// Optional build macro: GATE_BIST_CONT_EN (continuous back-to-back runs,
// results sticky until reset).
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [Y_W-1:0]   y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [Y_W-1:0]   fail_mask,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(3);

  state_e             state, state_n;
  logic [VEC_W-1:0]   vec, vec_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [Y_W-1:0]     mask_n;
  logic [VEC_W-1:0]   ffv_n;
  logic               pass_n, busy_n, done_n;
  logic [Y_W-1:0]     expected_c;
  logic [Y_W-1:0]     mismatch_c;

  // Stimulus comes straight from the vector register
  assign a = vec[1];
  assign b = vec[0];

  gate_ref_model u_ref (
    .a          (a),
    .b          (b),
    .expected_c (expected_c)
  );

  assign mismatch_c = y ^ expected_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    mask_n  = fail_mask;
    ffv_n   = first_fail_vec;
    pass_n  = pass;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SETTLE;
          vec_n   = '0;
          cnt_n   = '0;
          mask_n  = '0;
          ffv_n   = '0;
          pass_n  = 1'b0;
        end
      end
      ST_SETTLE: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        mask_n = fail_mask | mismatch_c;
        if ((fail_mask == '0) && (mismatch_c != '0)) ffv_n = vec;
        if (vec == VEC_LAST) begin
          state_n = ST_DONE;
          pass_n  = (mask_n == '0);
        end else begin
          state_n = ST_SETTLE;
          vec_n   = vec + VEC_W'(1);
          cnt_n   = '0;
        end
      end
      ST_DONE: begin
`ifdef GATE_BIST_CONT_EN
        state_n = ST_SETTLE;
        vec_n   = '0;
        cnt_n   = '0;
`else
        state_n = ST_IDLE;
`endif
      end
      default: state_n = ST_IDLE;
    endcase
    done_n = (state_n == ST_DONE);
    busy_n = (state_n == ST_SETTLE) || (state_n == ST_CHECK);
  end

  // Result, counter and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec            <= '0;
      cnt            <= '0;
      fail_mask      <= '0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      vec            <= vec_n;
      cnt            <= cnt_n;
      fail_mask      <= mask_n;
      first_fail_vec <= ffv_n;
      pass           <= pass_n;
      busy           <= busy_n;
      done           <= done_n;
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// Directed self-checking bench for gate_bist (SETTLE=1 and SETTLE=3 instances).
module tb_gate_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start2;
  logic       a1, b1, busy1, done1, pass1;
  logic       a2, b2, busy2, done2, pass2;
  logic [7:0] y1, y2, mask1, mask2;
  logic [1:0] ffv1, ffv2;
  logic [7:0] and_m, xor_m;
  logic       g2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // Hand-derived truth table, y7..y0 = XNOR NOR NAND NOT(b) XOR OR AND BUF(a)
  function automatic logic [7:0] tb_gate(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 8'hF0;
      2'b01:   return 8'h2C;
      2'b10:   return 8'h3D;
      2'b11:   return 8'h87;
      default: return 8'h00;
    endcase
  endfunction

  assign y1 = (tb_gate(a1, b1) & and_m) ^ xor_m;
  assign y2 = g2 ? ~tb_gate(a2, b2) : tb_gate(a2, b2);

  gate_bist #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1),
    .first_fail_vec(ffv1)
  );

  gate_bist #(.SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_mask(mask2),
    .first_fail_vec(ffv2)
  );

  // One start pulse on dut1 and 12 observed cycles (cycle k = T+k)
  task automatic run1(input logic [7:0] am, input logic [7:0] xm,
                      output int done_at, output int ndone,
                      output logic seq_ok, output logic busy_ok);
    and_m = am;
    xor_m = xm;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    done_at = -1; ndone = 0; seq_ok = 1'b1; busy_ok = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (done1 === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (busy1 !== 1'(k <= 8)) busy_ok = 1'b0;
      if ((k % 2 == 0) && (k <= 8) && ({a1, b1} !== 2'(k / 2 - 1))) seq_ok = 1'b0;
      @(posedge clk); #1;
    end
    and_m = 8'hFF;
    xor_m = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; g2 = 1'b0;
    and_m = 8'hFF; xor_m = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a1, b1, busy1, done1, pass1, mask1, ffv1} !== 15'h0) begin
      errors++;
      $display("FAIL reset_dut1: got %h expected 0", {a1, b1, busy1, done1, pass1, mask1, ffv1});
    end
    checks++;
    if ({a2, b2, busy2, done2, pass2, mask2, ffv2} !== 15'h0) begin
      errors++;
      $display("FAIL reset_dut2: got %h expected 0", {a2, b2, busy2, done2, pass2, mask2, ffv2});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy1, done1, pass1, mask1} !== 11'h0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 0", {busy1, done1, pass1, mask1});
    end
  endtask

  task automatic test_golden();
    int d, n; logic s, bz;
    run1(8'hFF, 8'h00, d, n, s, bz);
    checks++; if (d !== 9) begin errors++; $display("FAIL golden_done_cycle: got %0d expected 9", d); end
    checks++; if (n !== 1) begin errors++; $display("FAIL golden_done_count: got %0d expected 1", n); end
    checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL golden_pass: got %b expected 1", pass1); end
    checks++; if (mask1 !== 8'h00) begin errors++; $display("FAIL golden_mask: got %h expected 00", mask1); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL golden_ab_sequence: got %b expected 1", s); end
    checks++; if (bz !== 1'b1) begin errors++; $display("FAIL golden_busy_window: got %b expected 1", bz); end
    checks++; if ({a1, b1} !== 2'b11) begin errors++; $display("FAIL golden_ab_hold: got %b expected 11", {a1, b1}); end
  endtask

  task automatic test_stuck_y3();
    int d, n; logic s, bz;
    run1(8'hF7, 8'h00, d, n, s, bz);
    checks++; if (d !== 9) begin errors++; $display("FAIL y3_done_cycle: got %0d expected 9", d); end
    checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL y3_pass: got %b expected 0", pass1); end
    checks++; if (mask1 !== 8'h08) begin errors++; $display("FAIL y3_mask: got %h expected 08", mask1); end
    checks++; if (ffv1 !== 2'b01) begin errors++; $display("FAIL y3_first_vec: got %b expected 01", ffv1); end
  endtask

  task automatic test_inv_y7();
    int d, n; logic s, bz;
    run1(8'hFF, 8'h80, d, n, s, bz);
    checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL y7_pass: got %b expected 0", pass1); end
    checks++; if (mask1 !== 8'h80) begin errors++; $display("FAIL y7_mask: got %h expected 80", mask1); end
    checks++; if (ffv1 !== 2'b00) begin errors++; $display("FAIL y7_first_vec: got %b expected 00", ffv1); end
  endtask

  // Garbage on y except during the four CHECK cycles T+4/8/12/16
  task automatic test_settle3();
    int d;
    d = -1;
    g2 = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      g2 = (k % 4 != 0);
      if ((done2 === 1'b1) && (d < 0)) d = k;
      @(posedge clk); #1;
    end
    g2 = 1'b0;
    checks++; if (d !== 17) begin errors++; $display("FAIL settle3_done_cycle: got %0d expected 17", d); end
    checks++; if (pass2 !== 1'b1) begin errors++; $display("FAIL settle3_pass: got %b expected 1", pass2); end
    checks++; if (mask2 !== 8'h00) begin errors++; $display("FAIL settle3_mask: got %h expected 00", mask2); end
  endtask

  task automatic test_back_to_back();
    int d, n;
    d = -1; n = 0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      start1 = (k == 3);
      if (done1 === 1'b1) begin
        n++;
        if (d < 0) d = k;
      end
      @(posedge clk); #1;
    end
    start1 = 1'b0;
    checks++; if (d !== 9) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 9", d); end
    checks++; if (n !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", n); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", busy1); end
  endtask

  task automatic test_reset_midrun();
    int n;
    n = 0;
    xor_m = 8'h80;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) rst_n = 1'b0;
      if (k == 4) begin
        checks++;
        if (mask1 !== 8'h80) begin errors++; $display("FAIL midrun_partial_mask: got %h expected 80", mask1); end
      end
      if (k == 6) begin
        checks++;
        if ({a1, b1, busy1, done1, pass1, mask1, ffv1} !== 15'h0) begin
          errors++;
          $display("FAIL midrun_reset_values: got %h expected 0", {a1, b1, busy1, done1, pass1, mask1, ffv1});
        end
        rst_n = 1'b1;
      end
      if (done1 === 1'b1) n++;
      @(posedge clk); #1;
    end
    xor_m = 8'h00;
    checks++; if (n !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d pulses expected 0", n); end
  endtask

  // Continuous mode: fault (y1 inverted) present only during run 2
  task automatic test_cont();
    int dc[3];
    logic pc[3];
    int n;
    logic b9, b10;
    n = 0; b9 = 1'b1; b10 = 1'b0;
    for (int i = 0; i < 3; i++) begin dc[i] = -1; pc[i] = 1'bx; end
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 10) xor_m = 8'h02;
      if (k == 18) xor_m = 8'h00;
      if (k == 9) b9 = busy1;
      if (k == 10) b10 = busy1;
      if (done1 === 1'b1) begin
        if (n < 3) begin dc[n] = k; pc[n] = pass1; end
        n++;
      end
      @(posedge clk); #1;
    end
    checks++; if (dc[0] !== 9)  begin errors++; $display("FAIL cont_done1: got %0d expected 9", dc[0]); end
    checks++; if (dc[1] !== 18) begin errors++; $display("FAIL cont_done2: got %0d expected 18", dc[1]); end
    checks++; if (dc[2] !== 27) begin errors++; $display("FAIL cont_done3: got %0d expected 27", dc[2]); end
    checks++; if (n !== 3) begin errors++; $display("FAIL cont_done_count: got %0d expected 3", n); end
    checks++; if (pc[0] !== 1'b1) begin errors++; $display("FAIL cont_pass1: got %b expected 1", pc[0]); end
    checks++; if (pc[1] !== 1'b0) begin errors++; $display("FAIL cont_pass2: got %b expected 0", pc[1]); end
    checks++; if (pc[2] !== 1'b0) begin errors++; $display("FAIL cont_pass3: got %b expected 0", pc[2]); end
    checks++; if (mask1 !== 8'h02) begin errors++; $display("FAIL cont_sticky_mask: got %h expected 02", mask1); end
    checks++; if (ffv1 !== 2'b00) begin errors++; $display("FAIL cont_first_vec: got %b expected 00", ffv1); end
    checks++; if (b9 !== 1'b0) begin errors++; $display("FAIL cont_busy_in_done: got %b expected 0", b9); end
    checks++; if (b10 !== 1'b1) begin errors++; $display("FAIL cont_busy_rerun: got %b expected 1", b10); end
  endtask

  initial begin
    test_reset();
`ifdef GATE_BIST_CONT_EN
    test_cont();
`else
    test_golden();
    test_stuck_y3();
    test_inv_y7();
    test_settle3();
    test_back_to_back();
    test_reset_midrun();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
